// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch front end.
//
// Issues one fetch at a time to memory, waits for the in-order response,
// then holds the instruction until downstream takes it. A branch redirect
// reloads the PC and squashes whatever is in flight or held.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   stall                        blocks issue of new fetch requests
//   branch_valid/branch_target   redirect; PC <= branch_target next cycle
//   mem_req_valid/addr/ready     fetch request handshake
//   mem_resp_valid/data          read response (in order, one outstanding)
//   instr_valid/data/pc/ready    instruction handshake to downstream
//   program_counter_value        PC of the next fetch
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_STEP      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] program_counter_value
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_addr;       // address of the request in flight
  logic                  r_kill;       // in-flight response must be dropped
  logic [DATA_WIDTH-1:0] r_instr_data;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  w_req_valid;
  logic                  w_instr_valid;
  logic                  w_req_fire;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (w_req_fire) w_state_nxt = S_WAIT;
      // A response that is killed (earlier or same-cycle branch) returns
      // straight to FETCH instead of presenting an instruction.
      S_WAIT:  if (mem_resp_valid)
                 w_state_nxt = (r_kill || branch_valid) ? S_FETCH : S_HOLD;
      S_HOLD:  if (branch_valid || instr_ready) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    w_req_valid   = (r_state == S_FETCH) && !stall && !branch_valid;
    w_instr_valid = (r_state == S_HOLD);
  end

  assign w_req_fire = w_req_valid && mem_req_ready;

  // Datapath: PC, request address, kill flag, held instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_addr       <= '0;
      r_kill       <= 1'b0;
      r_instr_data <= '0;
      r_instr_pc   <= '0;
    end else begin
      // Branch wins over increment; the sum wraps at ADDR_WIDTH.
      if (branch_valid)    r_pc <= branch_target;
      else if (w_req_fire) r_pc <= r_pc + ADDR_WIDTH'(PC_STEP);

      if (w_req_fire) r_addr <= r_pc;

      if (r_state == S_WAIT) begin
        if (mem_resp_valid) begin
          r_kill <= 1'b0;
          if (!r_kill && !branch_valid) begin
            r_instr_data <= mem_resp_data;
            r_instr_pc   <= r_addr;
          end
        end else if (branch_valid) begin
          // Repeated branches leave it set: still exactly one response to drop.
          r_kill <= 1'b1;
        end
      end
    end
  end

  assign mem_req_valid         = w_req_valid;
  assign mem_req_addr          = r_pc;
  assign instr_valid           = w_instr_valid;
  assign instr_data            = r_instr_data;
  assign instr_pc              = r_instr_pc;
  assign program_counter_value = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the fetch unit.
module tb_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall, branch_valid, mem_req_ready, mem_resp_valid, instr_ready;
  logic [31:0] branch_target, mem_resp_data;
  logic        mem_req_valid, instr_valid;
  logic [31:0] mem_req_addr, instr_data, instr_pc, pc_val;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .program_counter_value(pc_val)
  );

  // Narrow instance for PC wrap: 8-bit addresses, step 4, starting at 0xFC.
  logic       u2_reset;
  logic       u2_req_valid, u2_instr_valid;
  logic [7:0] u2_req_addr, u2_instr_pc, u2_pc;
  logic [31:0] u2_instr_data;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_VECTOR(8'hFC), .PC_STEP(4)) u2 (
    .clock(clock), .reset(u2_reset), .stall(1'b0),
    .branch_valid(1'b0), .branch_target(8'h00),
    .mem_req_valid(u2_req_valid), .mem_req_addr(u2_req_addr),
    .mem_req_ready(1'b1), .mem_resp_valid(1'b0), .mem_resp_data(32'h0),
    .instr_valid(u2_instr_valid), .instr_data(u2_instr_data),
    .instr_pc(u2_instr_pc), .instr_ready(1'b0),
    .program_counter_value(u2_pc)
  );

  int tests = 0, fails = 0, cyc = 0;
  bit auto_mem;   // memory answers the cycle after acceptance with 10*addr

  // Reference model: transaction flags, not FSM states
  logic [31:0] m_pc, m_raddr, m_idata, m_ipc;
  bit          m_pending, m_kill, m_have;

  int          acc_cyc[$];
  logic [31:0] acc_pc[$], acc_data[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_raddr = 32'h0; m_idata = 32'h0; m_ipc = 32'h0;
    m_pending = 0; m_kill = 0; m_have = 0;
  endtask

  // One cycle: settle, compare, advance model, cross the clock edge.
  task automatic step();
    bit exp_req, fire;
    if (auto_mem) begin
      mem_resp_valid = m_pending;
      mem_resp_data  = m_raddr * 10;
    end
    #1;
    exp_req = !m_pending && !m_have && !stall && !branch_valid;
    chkb("mem_req_valid", mem_req_valid, exp_req);
    if (exp_req) chk("mem_req_addr", mem_req_addr, m_pc);
    chk("pc", pc_val, m_pc);
    chkb("instr_valid", instr_valid, m_have);
    chk("instr_data", instr_data, m_idata);
    chk("instr_pc", instr_pc, m_ipc);

    fire = exp_req && mem_req_ready;
    if (reset) model_reset();
    else begin
      if (m_have) begin
        if (!branch_valid && instr_ready) begin
          acc_cyc.push_back(cyc); acc_pc.push_back(m_ipc); acc_data.push_back(m_idata);
        end
        if (branch_valid || instr_ready) m_have = 0;
      end else if (m_pending) begin
        if (mem_resp_valid) begin
          m_pending = 0;
          if (!m_kill && !branch_valid) begin
            m_have = 1; m_idata = mem_resp_data; m_ipc = m_raddr;
          end
          m_kill = 0;
        end else if (branch_valid) m_kill = 1;
      end else if (fire) begin
        m_pending = 1; m_raddr = m_pc;
      end
      if (branch_valid) m_pc = branch_target;
      else if (fire)    m_pc = m_pc + 1;
    end
    @(posedge clock); cyc++;
    @(negedge clock);
  endtask

  initial begin
    reset = 1; stall = 0; branch_valid = 0; branch_target = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = 0; instr_ready = 1;
    u2_reset = 1; auto_mem = 1;
    @(posedge clock); @(negedge clock);
    model_reset();
    reset = 0;
    cyc = 0;

    // Back-to-back fetches: pc 0,1,2 with data 0,10,20, three cycles apart
    repeat (9) step();
    chk("seq_count", acc_pc.size(), 3);
    if (acc_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", acc_pc[i], i);
        chk("seq_data", acc_data[i], i * 10);
      end
      chk("seq_gap1", acc_cyc[1] - acc_cyc[0], 3);
      chk("seq_gap2", acc_cyc[2] - acc_cyc[1], 3);
    end

    // Stall in FETCH at PC=5
    repeat (6) step();
    chk("pre_stall_pc", pc_val, 32'd5);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chkb("stall_req", mem_req_valid, 1'b0);
      chk("stall_pc", pc_val, 32'd5);
      step();
    end
    stall = 0;
    #1;
    chkb("unstall_req", mem_req_valid, 1'b1);
    chk("unstall_addr", mem_req_addr, 32'd5);
    repeat (3) step();

    // Branch to 0x40 while the fetch of 6 is pending; its response is dropped
    step();
    auto_mem = 0; mem_resp_valid = 0;
    branch_valid = 1; branch_target = 32'h40;
    step();
    branch_valid = 0;
    step();
    mem_resp_valid = 1; mem_resp_data = 32'h1234;
    step();
    mem_resp_valid = 0;
    #1;
    chkb("kill_no_instr", instr_valid, 1'b0);
    chkb("kill_next_req", mem_req_valid, 1'b1);
    chk("kill_next_addr", mem_req_addr, 32'h40);

    // Downstream backpressure in HOLD
    auto_mem = 1;
    step(); step();
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chkb("hold_valid", instr_valid, 1'b1);
      chk("hold_pc", instr_pc, 32'h40);
      chk("hold_data", instr_data, 32'h280);
      chkb("hold_no_req", mem_req_valid, 1'b0);
      step();
    end
    instr_ready = 1;
    step();
    #1;
    chkb("release_req", mem_req_valid, 1'b1);
    chk("release_addr", mem_req_addr, 32'h41);

    // Reset with a branch while holding an instruction
    instr_ready = 0;
    step(); step();
    reset = 1; branch_valid = 1; branch_target = 32'h99;
    step();
    reset = 0; branch_valid = 0; instr_ready = 1;
    #1;
    chk("rst_pc", pc_val, 32'h0);
    chkb("rst_instr_valid", instr_valid, 1'b0);
    chkb("rst_req", mem_req_valid, 1'b1);
    chk("rst_instr_pc", instr_pc, 32'h0);
    step();

    // Random traffic, including spurious responses and resets mid-flight
    auto_mem = 0;
    for (int i = 0; i < 500; i++) begin
      reset          = ($urandom_range(0, 49) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      branch_valid   = ($urandom_range(0, 7) == 0);
      branch_target  = $urandom;
      mem_req_ready  = $urandom_range(0, 1);
      mem_resp_valid = m_pending ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mem_resp_data  = $urandom;
      instr_ready    = $urandom_range(0, 1);
      step();
    end
    reset = 0; stall = 0; branch_valid = 0;

    // PC wrap on the narrow instance
    u2_reset = 0;
    #1;
    chk("wrap_pc_before", 32'(u2_pc), 32'hFC);
    chkb("wrap_req", u2_req_valid, 1'b1);
    chk("wrap_addr", 32'(u2_req_addr), 32'hFC);
    @(posedge clock); @(negedge clock);
    #1;
    chk("wrap_pc_after", 32'(u2_pc), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
